// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with round-robin or fixed-select arbitration.
// Each output word is tagged with its source channel in out_ch.

module stream_mux_rr_lane #(
  parameter int WIDTH = 5,
  parameter int SELW  = 2,
  parameter int IDX   = 0
) (
  input  logic             take,
  input  logic [SELW-1:0]  gnt_idx,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic [WIDTH-1:0] data_m
);
  logic hit;
  assign hit    = (gnt_idx == SELW'(IDX));
  assign ready  = take && hit;
  assign data_m = hit ? data : '0;
endmodule

module stream_mux_rr #(
  parameter int WIDTH = 5,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_ch
);
  typedef struct packed {
    logic [SELW-1:0]  ch;
    logic [WIDTH-1:0] data;
  } word_t;

  word_t                  out_q;
  logic [SELW-1:0]        ptr;
  logic [SELW-1:0]        gnt_idx;
  logic                   gnt_vld;
  logic                   load_en;
  logic                   take;
  logic [N-1:0][WIDTH-1:0] lane_d;
  logic [WIDTH-1:0]       mux_data;

  assign load_en = !out_valid || out_ready;
  assign take    = load_en && gnt_vld && !reset;

  // Round-robin picks the valid channel at the smallest rotated distance from ptr.
  always_comb begin
    int best;
    int d;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    best    = N;
    d       = 0;
    for (int i = 0; i < N; i++) begin
      if (mode) begin
        if (in_valid[i] && sel == SELW'(i)) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(i);
        end
      end else begin
        d = (i + N - int'(ptr)) % N;
        if (in_valid[i] && d < best) begin
          best    = d;
          gnt_vld = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    stream_mux_rr_lane #(.WIDTH(WIDTH), .SELW(SELW), .IDX(i)) u_lane (
      .take    (take),
      .gnt_idx (gnt_idx),
      .data    (in_data[i*WIDTH +: WIDTH]),
      .ready   (in_ready[i]),
      .data_m  (lane_d[i])
    );
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++) mux_data = mux_data | lane_d[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (take) begin
      out_q.data <= mux_data;
      out_q.ch   <= gnt_idx;
      out_valid  <= 1'b1;
      // Explicit wrap keeps ptr legal when N is not a power of two.
      ptr        <= (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_data = out_q.data;
  assign out_ch   = out_q.ch;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance plus a 3-channel one
// for the out-of-range select and non-power-of-two pointer wrap.

module tb_stream_mux_rr;
  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [1:0]  sel;
  logic [19:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [4:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;

  logic        mode3;
  logic [1:0]  sel3;
  logic [14:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [4:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_ch3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(5), .N(4)) u_dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch)
  );

  stream_mux_rr #(.WIDTH(5), .N(3)) u_dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_ch(out_ch3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [4:0] d, input logic [1:0] c);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".ch"},    32'(out_ch),    32'(c));
  endtask

  initial begin
    reset      = 1'b1;
    mode       = 1'b0;
    sel        = 2'd0;
    in_data    = {5'd13, 5'd12, 5'd11, 5'd10};
    in_valid   = 4'b1111;
    out_ready  = 1'b1;
    mode3      = 1'b1;
    sel3       = 2'd3;
    in_data3   = {5'd22, 5'd21, 5'd20};
    in_valid3  = 3'b000;
    out_ready3 = 1'b1;

    step();
    step();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.valid",    32'(out_valid), 32'd0);
    chk("rst.data",     32'(out_data),  32'd0);

    // Round-robin over four valid channels, one word per cycle.
    reset = 1'b0;
    #1;
    chk("rr.first_ready", 32'(in_ready), 32'b0001);
    step(); chk_word("rr0", 5'd10, 2'd0);
    step(); chk_word("rr1", 5'd11, 2'd1);
    step(); chk_word("rr2", 5'd12, 2'd2);
    step(); chk_word("rr3", 5'd13, 2'd3);
    step(); chk_word("rr4", 5'd10, 2'd0);

    // Reset mid-stream clears the held word immediately.
    reset = 1'b1;
    #1;
    chk("midrst.valid", 32'(out_valid), 32'd0);
    chk("midrst.data",  32'(out_data),  32'd0);
    chk("midrst.ch",    32'(out_ch),    32'd0);
    reset = 1'b0;
    step(); chk_word("postrst", 5'd10, 2'd0);

    // Skip idle channels, then wrap to channel 0.
    in_valid = 4'b1010;
    step(); chk_word("skip0", 5'd11, 2'd1);
    step(); chk_word("skip1", 5'd13, 2'd3);
    step(); chk_word("skip2", 5'd11, 2'd1);
    step(); chk_word("skip3", 5'd13, 2'd3);
    in_valid = 4'b0001;
    step(); chk_word("wrap", 5'd10, 2'd0);

    // Backpressure holds the word; release drains and refills on one edge.
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #1;
    chk("bp.in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_word("bp.hold", 5'd10, 2'd0);
      chk("bp.in_ready_hold", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(in_ready), 32'b0010);
    step(); chk_word("bp.refill", 5'd11, 2'd1);

    // Fixed select.
    mode = 1'b1;
    sel  = 2'd2;
    #1;
    chk("fix.in_ready", 32'(in_ready), 32'b0100);
    step(); chk_word("fix0", 5'd12, 2'd2);
    step(); chk_word("fix1", 5'd12, 2'd2);
    in_valid = 4'b1011;
    #1;
    chk("fix.nogrant_ready", 32'(in_ready), 32'd0);
    step();
    chk("fix.drain_valid", 32'(out_valid), 32'd0);
    chk("fix.drain_data",  32'(out_data),  32'd12);
    chk("fix.drain_ch",    32'(out_ch),    32'd2);

    // Three-channel instance: sel out of range, then in range, then wrap.
    in_valid3 = 3'b111;
    #1;
    chk("n3.sel3_ready", 32'(in_ready3), 32'd0);
    step();
    chk("n3.sel3_valid", 32'(out_valid3), 32'd0);
    sel3 = 2'd2;
    #1;
    chk("n3.sel2_ready", 32'(in_ready3), 32'b100);
    step();
    chk("n3.sel2_data", 32'(out_data3), 32'd22);
    chk("n3.sel2_ch",   32'(out_ch3),   32'd2);
    mode3 = 1'b0;
    #1;
    chk("n3.wrap_ready", 32'(in_ready3), 32'b001);
    step();
    chk("n3.wrap_ch", 32'(out_ch3), 32'd0);

    // Mode switch resumes round-robin after the last fixed-select channel.
    in_valid = 4'b1111;
    sel      = 2'd1;
    step(); chk_word("sw0", 5'd11, 2'd1);
    step(); chk_word("sw1", 5'd11, 2'd1);
    mode = 1'b0;
    #1;
    chk("sw.ready", 32'(in_ready), 32'b0100);
    step(); chk_word("sw2", 5'd12, 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshakes on every input and on the output. It generalises the 2:1 combinational select into a clocked block. Two selection modes are supported:
- **Round-robin:** fair arbitration among the active channels.
- **Fixed select:** an external `sel` chooses the channel.

The block sits between several producer streams and one consumer. It provides one output register stage and reports which channel each output word came from.

## Interface
- `WIDTH`, default 5: data width of every channel and of the output.
- `N`, default 4: number of input channels. Legal range is N ≥ 2.
- `SELW`, default $clog2(N): width of `sel`, `out_ch` and the internal pointer.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mode`  in  1  0 = round-robin, 1 = fixed select.
- `sel`  in  SELW  channel index used when mode = 1.
- `in_data`  in  N*WIDTH  channel i occupies `in_data[i*WIDTH +: WIDTH]`.
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready, at most one bit high.
- `out_data`  out  WIDTH  registered output word.
- `out_valid`  out  1  `out_data` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts the word.
- `out_ch`  out  SELW  source channel of `out_data`.

## Operation
- **Load enable:** `load_en = !out_valid || out_ready`. The output register can take a new word whenever it is empty or being drained in the same cycle.
- **Grant, mode 0:** the first i with `in_valid[i]`, searching from `ptr`, `ptr+1`, … with wrap modulo N.
- **Grant, mode 1:** the grant is `sel` if `sel < N` and `in_valid[sel]`. Otherwise there is no grant; an out-of-range `sel` never grants.
- **Ready:** `in_ready[g] = load_en && grant exists`. All other `in_ready` bits are 0. `in_ready` is combinational from `in_valid`, `mode`, `sel`, `out_ready` and state.
- **Input transfer:** occurs when `in_valid[g] && in_ready[g]`. On the clock edge:
  - `out_data` ← channel g data
  - `out_ch` ← g
  - `out_valid` ← 1
  - `ptr` ← (g+1) mod N, with wrap from N−1 to 0 (this also holds when N is not a power of 2)
- **Output drain without refill:** if `out_ready && out_valid` and there is no input transfer, `out_valid` ← 0. `out_data` and `out_ch` hold their values.
- **Stall:** if `out_valid && !out_ready`, all `in_ready` are 0. `out_data`, `out_ch` and `ptr` hold.
- **Pointer update:** `ptr` updates on every transfer in both modes, so switching to mode 0 resumes after the last-served channel.
- **Mode or sel changes:** take effect in the same cycle and never corrupt a word already in the output register.
- **Producer rules:** a producer may drop `in_valid` without a handshake. The block does not require producers to hold valid.

## Timing
- **Reset (async assert, any time, including mid-transfer):**
  - `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `ptr` = 0
  - all `in_ready` = 0 while reset is high
  - any pending output word is discarded
- **Latency:** 1 cycle. A word accepted at edge k is visible with `out_valid` = 1 after edge k.
- **Throughput:** 1 word/cycle sustained when `out_ready` is held high.
- **Simultaneous drain and refill:** `out_valid` stays 1 and the register takes the new word. There is no bubble.
- **No combinational path** from any `in_data` to `out_data`.

## Test plan
1. **Reset:** assert `reset` mid-stream with `out_valid` = 1.
   - `out_valid`, `out_data`, `out_ch` = 0 immediately.
   - After release with all `in_valid` = 1 (mode 0), the first grant is channel 0.
2. **Round-robin fairness:** mode 0, all four channels valid, channel i data = i+10, `out_ready` = 1.
   - Output sequence 10, 11, 12, 13, 10… with `out_ch` 0, 1, 2, 3, 0, one word per cycle.
3. **Skip and wrap:** mode 0, only channels 1 and 3 valid.
   - Grants alternate 1, 3, 1, 3.
   - Then only channel 0 valid after a grant on 3: the pointer wraps and channel 0 is granted next cycle.
4. **Backpressure:** `out_ready` = 0 with a word held.
   - `in_ready` = 0, and `out_data`/`out_ch` are stable for 5 cycles.
   - When `out_ready` rises, the held word drains and a new word loads on the same edge with no bubble.
5. **Fixed select:** mode 1.
   - `sel` = 2 with `in_valid` = 4'b1111: only channel 2 is served.
   - `sel` = 2 with `in_valid[2]` = 0: no grant, `out_valid` falls after the drain.
   - For N = 3, `sel` = 3: no grant.
6. **Mode switch:** mode 1 `sel` = 1 for 2 transfers, then mode 0 with all channels valid.
   - The next grant is channel 2.
